// File: rtl/sobel_stream_pkg.sv
// Shared types and helpers for the streaming Sobel edge engine: FSM state
// encoding, gradient magnitude width and the output saturation function.
package sobel_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_PIX_W = 8;
  localparam int MAG_W     = DEF_PIX_W + 3;

  // Gradient magnitude width for a given pixel width (|Gx|+|Gy| <= 8*(2^PIX_W-1)).
  function automatic int mag_width(input int pix_w);
    return pix_w + 3;
  endfunction

  // Clamp a magnitude to the largest value representable in pix_w bits.
  function automatic logic [31:0] saturate(input logic [31:0] mag, input int pix_w);
    logic [31:0] max_val;
    max_val = (32'd1 << pix_w) - 32'd1;
    return (mag > max_val) ? max_val : mag;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer: both rows share one column address, one synchronous
// read port (1-cycle latency) and one write port for the shifted rows.
module sobel_line_buffer #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 1024,
  parameter int AW    = $clog2(MAX_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_line0,
  input  logic [PIX_W-1:0] wr_line1,
  output logic [PIX_W-1:0] rd_line0,
  output logic [PIX_W-1:0] rd_line1
);

  logic [2*PIX_W-1:0] mem [MAX_W];

  // NOTE: the RAM and its read register carry no reset so the array maps onto
  // block RAM; stale rows are never consumed before two fresh rows are written.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= {wr_line1, wr_line0};
    {rd_line1, rd_line0} <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming Sobel edge core: raster pixels in, (H-2)x(W-2) gradient image out
// over valid/ready. Define SOBEL_THRESH_EN to build the binarising threshold.
module sobel_stream_core
  import sobel_stream_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 1024,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic             thresh_mode,
  input  logic [PIX_W-1:0] threshold,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             dim_err
);

  localparam int MW = mag_width(PIX_W);
  localparam int AW = $clog2(MAX_W);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  state_t           state;
  logic [DIM_W-1:0] w_q, h_q, row, col, col_nxt;
  logic             accept, col_last, row_last, produce, dims_bad;

  // Two retained window columns per row; the newest column comes live from
  // the line buffer (rows r-2, r-1) and the incoming pixel (row r).
  logic [PIX_W-1:0] top_a, top_b, mid_a, mid_b, bot_a, bot_b;
  logic [PIX_W-1:0] lb_top, lb_mid;

  logic [MW-1:0]        sum_r, sum_l, sum_b, sum_t, abs_gx, abs_gy, mag;
  logic signed [MW-1:0] gx, gy;
  logic [PIX_W-1:0]     mag_sat, pix_out;

`ifdef SOBEL_THRESH_EN
  logic             thr_mode_q;
  logic [PIX_W-1:0] thr_q;
`else
  logic             unused_thresh;
  assign unused_thresh = ^{thresh_mode, threshold};
`endif

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col == w_q - DIM_W'(1));
  assign row_last = (row == h_q - DIM_W'(1));
  assign produce  = (row >= DIM_W'(2)) && (col >= DIM_W'(2));
  assign dims_bad = (width < DIM_W'(3)) || (height < DIM_W'(3)) || (width > DIM_W'(MAX_W));

  // Read address runs one column ahead so the RAM word is ready on the accept.
  assign col_nxt = accept ? (col_last ? '0 : col + DIM_W'(1)) : col;

  sobel_line_buffer #(
    .PIX_W (PIX_W),
    .MAX_W (MAX_W),
    .AW    (AW)
  ) u_line_buffer (
    .clk      (clk),
    .we       (accept),
    .rd_addr  (AW'(col_nxt)),
    .wr_addr  (AW'(col)),
    .wr_line0 (lb_mid),
    .wr_line1 (in_data),
    .rd_line0 (lb_top),
    .rd_line1 (lb_mid)
  );

  // NOTE: combinational logic uses blocking '=' and assigns every output on
  // every path, so no latch is inferred; all clocked state below uses '<='.
  always_comb begin
    sum_r  = MW'(lb_top) + (MW'(lb_mid) << 1) + MW'(in_data);
    sum_l  = MW'(top_a)  + (MW'(mid_a)  << 1) + MW'(bot_a);
    sum_b  = MW'(bot_a)  + (MW'(bot_b)  << 1) + MW'(in_data);
    sum_t  = MW'(top_a)  + (MW'(top_b)  << 1) + MW'(lb_top);
    gx     = $signed(sum_r) - $signed(sum_l);
    gy     = $signed(sum_b) - $signed(sum_t);
    abs_gx = gx[MW-1] ? -gx : gx;
    abs_gy = gy[MW-1] ? -gy : gy;
    mag    = abs_gx + abs_gy;
    mag_sat = PIX_W'(saturate(32'(mag), PIX_W));
`ifdef SOBEL_THRESH_EN
    pix_out = thr_mode_q ? ((mag_sat >= thr_q) ? PIX_MAX : '0) : mag_sat;
`else
    pix_out = mag_sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dim_err   <= 1'b0;
      top_a     <= '0;
      top_b     <= '0;
      mid_a     <= '0;
      mid_b     <= '0;
      bot_a     <= '0;
      bot_b     <= '0;
`ifdef SOBEL_THRESH_EN
      thr_mode_q <= 1'b0;
      thr_q      <= '0;
`endif
    end else begin
      done    <= 1'b0;
      dim_err <= 1'b0;

      if (out_valid && out_ready) out_valid <= 1'b0;

      if (accept) begin
        top_a <= top_b;
        top_b <= lb_top;
        mid_a <= mid_b;
        mid_b <= lb_mid;
        bot_a <= bot_b;
        bot_b <= in_data;
        col   <= col_nxt;
        if (col_last) row <= row + DIM_W'(1);
        // Window spans cols c-2..c of the current row only once c >= 2.
        if (produce) begin
          out_valid <= 1'b1;
          out_data  <= pix_out;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (dims_bad) begin
              dim_err <= 1'b1;
            end else begin
              w_q   <= width;
              h_q   <= height;
              row   <= '0;
              col   <= '0;
              busy  <= 1'b1;
              state <= RUN;
`ifdef SOBEL_THRESH_EN
              thr_mode_q <= thresh_mode;
              thr_q      <= threshold;
`endif
            end
          end
        end
        RUN: begin
          if (accept && col_last && row_last) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Self-checking bench for sobel_stream_core: directed and random frames
// compared against a direct 3x3 Sobel evaluation of the stored image.
module tb_sobel_stream_core;

  localparam int PIX_W = 8;
  localparam int MAX_W = 32;
  localparam int DIM_W = 16;
  localparam int BUDGET = 4000;

  logic             clk;
  logic             reset;
  logic             start;
  logic [DIM_W-1:0] width;
  logic [DIM_W-1:0] height;
  logic             thresh_mode;
  logic [PIX_W-1:0] threshold;
  logic [PIX_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             dim_err;

  int checks = 0;
  int errors = 0;
  int img [1024];
  int exp_q [$];

  sobel_stream_core #(
    .PIX_W (PIX_W),
    .MAX_W (MAX_W),
    .DIM_W (DIM_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .width       (width),
    .height      (height),
    .thresh_mode (thresh_mode),
    .threshold   (threshold),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .dim_err     (dim_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int px(int w, int r, int c);
    return img[r*w + c];
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: Sobel at every interior pixel, raster order, from the image array.
  task automatic build_expected(int w, int h, int mode, int thr);
    int gx, gy, mag;
    exp_q.delete();
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        gx = (px(w, r-1, c+1) + 2*px(w, r, c+1) + px(w, r+1, c+1))
           - (px(w, r-1, c-1) + 2*px(w, r, c-1) + px(w, r+1, c-1));
        gy = (px(w, r+1, c-1) + 2*px(w, r+1, c) + px(w, r+1, c+1))
           - (px(w, r-1, c-1) + 2*px(w, r-1, c) + px(w, r-1, c+1));
        mag = iabs(gx) + iabs(gy);
        if (mag > 255) mag = 255;
`ifdef SOBEL_THRESH_EN
        if (mode != 0) mag = (mag >= thr) ? 255 : 0;
`else
        if (mode != 0 && thr < 0) mag = 0;
`endif
        exp_q.push_back(mag);
      end
    end
  endtask

  task automatic reset_dut();
    reset       = 1'b1;
    start       = 1'b0;
    width       = '0;
    height      = '0;
    thresh_mode = 1'b0;
    threshold   = '0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start(int w, int h, int mode, int thr);
    @(posedge clk);
    #1;
    start       = 1'b1;
    width       = DIM_W'(w);
    height      = DIM_W'(h);
    thresh_mode = mode[0];
    threshold   = PIX_W'(thr);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Streams img through the DUT; const_exp >= 0 replaces the model with a fixed value.
  task automatic run_frame(string name, int w, int h, int mode, int thr,
                           int stall, int full_rate, int const_exp);
    int n_exp;
    if (const_exp < 0) begin
      build_expected(w, h, mode, thr);
    end else begin
      exp_q.delete();
      for (int i = 0; i < (w-2)*(h-2); i++) exp_q.push_back(const_exp);
    end
    n_exp = exp_q.size();
    pulse_start(w, h, mode, thr);
    fork
      begin
        int idx = 0;
        int cyc = 0;
        while (idx < w*h && cyc < BUDGET) begin
          @(posedge clk);
          #1;
          in_valid = (full_rate != 0) ? 1'b1 : ($urandom_range(3) != 0);
          in_data  = PIX_W'(img[idx]);
          @(negedge clk);
          if (in_valid && in_ready) idx++;
          cyc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (idx != w*h) begin
          errors++;
          $display("FAIL %s accept_count: got %0d expected %0d", name, idx, w*h);
        end
        if (full_rate != 0) begin
          checks++;
          if (cyc != w*h) begin
            errors++;
            $display("FAIL %s throughput: took %0d cycles expected %0d", name, cyc, w*h);
          end
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [PIX_W-1:0] held = '0;
        while (got < n_exp && cyc < BUDGET) begin
          @(posedge clk);
          #1 out_ready = (stall == 0) ? 1'b1 : 1'($urandom_range(1));
          @(negedge clk);
          if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
              errors++;
              $display("FAIL %s stall_hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                       name, out_valid, out_data, held);
            end
          end
          if (out_valid && !out_ready) begin
            checks++;
            if (in_ready !== 1'b0) begin
              errors++;
              $display("FAIL %s stall_in_ready: got %0b expected 0", name, in_ready);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (out_data !== PIX_W'(exp_q[got])) begin
              errors++;
              $display("FAIL %s out[%0d]: got %0d expected %0d", name, got, out_data, exp_q[got]);
            end
            got++;
          end
          stalled = out_valid && !out_ready;
          held    = out_data;
          cyc++;
        end
        checks++;
        if (got != n_exp) begin
          errors++;
          $display("FAIL %s output_count: got %0d expected %0d", name, got, n_exp);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got done=%0b busy=%0b in_ready=%0b expected 1 0 0",
               name, done, busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: got %0b expected 0", name, done);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy, done, dim_err} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got ov=%0b ir=%0b busy=%0b done=%0b err=%0b data=%0d expected all 0",
               out_valid, in_ready, busy, done, dim_err, out_data);
    end
  endtask

  task automatic test_flat();
    reset_dut();
    for (int i = 0; i < 16; i++) img[i] = 100;
    run_frame("flat4x4", 4, 4, 0, 0, 0, 0, 0);
  endtask

  task automatic test_step();
    reset_dut();
    for (int i = 0; i < 16; i++) img[i] = ((i % 4) >= 2) ? 255 : 0;
    run_frame("step4x4", 4, 4, 0, 0, 0, 0, 255);
  endtask

  task automatic test_ramp();
    reset_dut();
    for (int i = 0; i < 15; i++) img[i] = 10 * (i % 5);
    run_frame("ramp5x3", 5, 3, 0, 0, 0, 0, 80);
`ifdef SOBEL_THRESH_EN
    run_frame("ramp5x3_thr50", 5, 3, 1, 50, 0, 0, 255);
    run_frame("ramp5x3_thr100", 5, 3, 1, 100, 0, 0, 0);
`endif
  endtask

  task automatic test_stall();
    reset_dut();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) img[r*7 + c] = (r*9 + c*23) % 256;
    run_frame("ramp7x6_stall", 7, 6, 0, 0, 1, 0, -1);
    for (int i = 0; i < 6*9; i++) img[i] = $urandom_range(255);
    run_frame("rand9x6_stall", 9, 6, 0, 0, 1, 0, -1);
`ifdef SOBEL_THRESH_EN
    run_frame("rand9x6_thr", 9, 6, 1, 128, 1, 0, -1);
`endif
  endtask

  task automatic test_dim_err();
    int bad_w [3] = '{2, MAX_W + 1, 4};
    int bad_h [3] = '{4, 4, 2};
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      pulse_start(bad_w[k], bad_h[k], 0, 0);
      @(negedge clk);
      checks++;
      if (dim_err !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL dim_err[%0d]: got err=%0b ir=%0b busy=%0b expected 1 0 0",
                 k, dim_err, in_ready, busy);
      end
      @(negedge clk);
      checks++;
      if (dim_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dim_err_pulse[%0d]: got err=%0b ir=%0b expected 0 0", k, dim_err, in_ready);
      end
    end
    for (int i = 0; i < 16; i++) img[i] = $urandom_range(255);
    run_frame("after_dim_err", 4, 4, 0, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int cyc = 0;
    reset_dut();
    for (int i = 0; i < 64; i++) img[i] = $urandom_range(255);
    pulse_start(8, 8, 0, 0);
    out_ready = 1'b1;
    while (acc < 12 && cyc < 100) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = PIX_W'(img[acc]);
      @(negedge clk);
      if (in_ready) acc++;
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: got ov=%0b busy=%0b ir=%0b expected 0 0 0",
               out_valid, busy, in_ready);
    end
    for (int i = 0; i < 16; i++) img[i] = $urandom_range(255);
    run_frame("after_reset_4x4", 4, 4, 0, 0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 30; i++) img[i] = $urandom_range(255);
    run_frame("b2b_first", 6, 5, 0, 0, 0, 1, -1);
    for (int i = 0; i < 30; i++) img[i] = $urandom_range(255);
    run_frame("b2b_second", 5, 6, 0, 0, 0, 1, -1);
    for (int i = 0; i < MAX_W*3; i++) img[i] = $urandom_range(255);
    run_frame("max_width", MAX_W, 3, 0, 0, 1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_ramp();
    test_stall();
    test_dim_err();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_stream_core.md
# sobel_stream_core

Parametrised streaming Sobel edge engine, next generation of the frame-buffered edge path. Pulls a raster-order grayscale pixel stream through two on-chip line buffers and emits the (H-2)x(W-2) interior gradient image as a valid/ready stream, so no full-frame RAM is needed. Sits between the rgb2gray stage and the UART transmitter, with backpressure from the transmitter. Optional threshold mode binarises the output.

## Interface
- PIX_W, 8: pixel bit width.
- MAX_W, 1024: maximum supported line width; sets line-buffer depth.
- DIM_W, 16: width of the height and width inputs.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse in IDLE; latches width, height, thresh_mode and threshold.
- width, height  in  DIM_W each  frame dimensions in pixels.
- thresh_mode  in  1  0 selects magnitude output; 1 selects binary output.
- threshold  in  PIX_W  binarisation level.
- in_data  in  PIX_W  grayscale pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  core accepts in_data this cycle.
- out_data  out  PIX_W  edge pixel.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of frame.
- dim_err  out  1  one-cycle pulse when start is rejected.

## Operation
- Every output resets to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + start:
  - If width<3, height<3 or width>MAX_W: pulse dim_err and stay in IDLE.
  - Otherwise clear the row and column counters and go to RUN.
- RUN:
  - A pixel is accepted when in_valid && in_ready.
  - On each accept the column's two line-buffer entries are read first, then shifted (line1 to line0, pixel to line1).
  - The 3x3 window shift registers advance on each accept.
  - col wraps at width-1 and increments row.
- Output generation:
  - Accepting pixel (r,c) with r>=2 and c>=2 produces the output centred at (r-1,c-1).
  - Window columns never span a line wrap.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20).
  - Gy = (p20+2p21+p22)-(p00+2p01+p02).
  - Gx and Gy are signed, PIX_W+3 bits.
  - mag = |Gx|+|Gy| in PIX_W+3 unsigned bits, saturated to 2^PIX_W-1.
  - Threshold mode: out = (mag >= threshold) ? 2^PIX_W-1 : 0, where mag is the saturated value.
- The last input pixel (row height-1, col width-1) moves the FSM to DRAIN.
- DRAIN: wait until the output register empties, then go to DONE.
- DONE: pulse done for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- in_ready is 0 in IDLE, DRAIN and DONE.
- reset mid-frame returns to IDLE with out_valid=0 and counters cleared. Line-buffer contents are not cleared (don't-care).

## Timing
- Output register is one entry deep; in_ready = RUN && (!out_valid || out_ready).
- Latency: out_valid rises on the cycle after the accept that produces it.
- out_data is held stable while out_valid && !out_ready.
- A simultaneous output handshake and new accept are allowed, giving full throughput of 1 pixel/clk.
- done is asserted on the cycle after the final output handshake.
- Line-buffer RAM has 1-cycle synchronous read. Read address is driven from the next-column value so data is available in the accept cycle.

## Configuration
- SOBEL_THRESH_EN defined: thresh_mode and threshold are latched and take effect as described above.
- SOBEL_THRESH_EN undefined: thresh_mode and threshold are ignored, the comparator is not built, and out = saturated mag.

## Structure
- Package sobel_stream_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the magnitude width localparam PIX_W+3;
  - the saturate function.
- Sub-module sobel_line_buffer: a 2-row, MAX_W-deep, PIX_W-wide dual-line RAM with shared column address. It returns both stored rows and writes the shifted rows.
- The window registers, FSM and arithmetic stay in the core.

## Test plan
- 4x4 frame, all pixels 100 -> 4 outputs of 0, then done pulse; busy falls.
- 4x4 frame, columns 0-1 = 0 and columns 2-3 = 255 -> 4 outputs of 255 (Gx=1020, saturated).
- 5x3 frame, pixel = 10*col -> 3 outputs of 80. With SOBEL_THRESH_EN, mode 1: threshold 50 -> 255, threshold 100 -> 0.
- Ramp frame with out_ready toggling randomly (about 50%) -> identical output sequence; in_ready is low whenever out_valid && !out_ready; out_data is stable during the stall.
- start with width=2 or width=MAX_W+1 -> one dim_err pulse, in_ready stays 0, and the next valid start runs normally.
- reset asserted mid-row of an 8x8 frame, then a new 4x4 start -> the outputs match a clean 4x4 run with no stale windows.
